// File: rtl/btn_pkg.sv
// btn_pkg: shared state type and counter sizing for the button debounce bank.
package btn_pkg;

    typedef enum logic [1:0] {RELEASED, HOLD_DELAY, HOLD_REPEAT} btn_state_t;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: synchroniser, debounce, edge pulses and hold-to-repeat for one button.
module btn_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_rpt
);

    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam int RW = cnt_w(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);

    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0]          dcnt;
    logic [RW-1:0]          rcnt;
    btn_state_t             state;
    logic                   s, flip, rise, fall, rexp;

    assign s    = sync[SYNC_STAGES-1];
    assign flip = (s != btn_level) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
    assign rise = flip && !btn_level;
    assign fall = flip && btn_level;
    assign rexp = rcnt == (state == HOLD_DELAY ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1));

    // Release is checked before expiry so a release never emits a repeat pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync        <= '0;
            dcnt        <= '0;
            rcnt        <= '0;
            state       <= RELEASED;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_rpt     <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], btn_in};
            dcnt        <= (s == btn_level || flip) ? '0 : dcnt + 1'b1;
            btn_level   <= btn_level ^ flip;
            btn_press   <= rise;
            btn_release <= fall;
            btn_rpt     <= 1'b0;
            if (rise) begin
                state   <= HOLD_DELAY;
                rcnt    <= '0;
                btn_rpt <= 1'b1;
            end else if (state != RELEASED) begin
                if (fall) begin
                    state <= RELEASED;
                    rcnt  <= '0;
                end else if (!repeat_en) begin
                    state <= HOLD_DELAY;
                    rcnt  <= '0;
                end else if (rexp) begin
                    state   <= HOLD_REPEAT;
                    rcnt    <= '0;
                    btn_rpt <= 1'b1;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/btn_debounce_bank.sv
// btn_debounce_bank: N_BTN independent debounced button channels with auto-repeat.
module btn_debounce_bank
    import btn_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_rpt
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn_in     (btn_in[i]),
            .repeat_en  (repeat_en[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_rpt    (btn_rpt[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_bank.sv
// tb_btn_debounce_bank: directed and random stimulus against a history-window reference model.
module tb_btn_debounce_bank;

    localparam int N   = 2;
    localparam int DEB = 4;
    localparam int DEL = 10;
    localparam int PER = 3;
    localparam int ME  = 8192;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] repeat_en = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_rpt;

    btn_debounce_bank #(
        .N_BTN          (N),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DEL),
        .REPEAT_PERIOD  (PER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .repeat_en  (repeat_en),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_rpt    (btn_rpt)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int t = 0;
    int base = 0;
    bit raw [N][ME];
    int last_tog [N];
    int ref_r [N];
    bit held [N];
    logic [N-1:0] e_lvl = '0, e_press = '0, e_rel = '0, e_rpt = '0;

    // Raw pin value sampled at edge k; anything sampled before reset release reads as 0.
    function automatic bit rv(input int c, input int k);
        return (k < base) ? 1'b0 : raw[c][k];
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s edge=%0d got=%b exp=%b", tag, t, got, exp);
        end
    endtask

    task automatic check_all();
        chk("level", btn_level, e_lvl);
        chk("press", btn_press, e_press);
        chk("release", btn_release, e_rel);
        chk("rpt", btn_rpt, e_rpt);
    endtask

    // Level flips once the last DEB synced samples all disagree with it since the previous flip.
    // Repeat pulses fall at ref+DEL+k*PER, where ref is the press or the last repeat_en=0 edge.
    task automatic model_edge(input int c, input bit en);
        bit ok;
        ok = (t - DEB >= last_tog[c]);
        for (int j = t - DEB + 1; j <= t; j++)
            if (rv(c, j - 2) == e_lvl[c]) ok = 1'b0;
        e_press[c] = 1'b0;
        e_rel[c]   = 1'b0;
        e_rpt[c]   = 1'b0;
        if (ok) begin
            e_lvl[c]    = ~e_lvl[c];
            last_tog[c] = t;
            if (e_lvl[c]) e_press[c] = 1'b1;
            else e_rel[c] = 1'b1;
        end
        if (e_press[c]) begin
            held[c]  = 1'b1;
            ref_r[c] = t;
            e_rpt[c] = 1'b1;
        end else if (e_rel[c]) begin
            held[c] = 1'b0;
        end else if (held[c]) begin
            if (!en) ref_r[c] = t;
            else e_rpt[c] = (t - ref_r[c] >= DEL) && ((t - ref_r[c] - DEL) % PER == 0);
        end
    endtask

    task automatic step();
        logic [N-1:0] b, e;
        @(posedge clk);
        b = btn_in;
        e = repeat_en;
        t++;
        if (rst)
            for (int c = 0; c < N; c++) begin
                raw[c][t] = b[c];
                model_edge(c, e[c]);
            end
        #1;
        check_all();
    endtask

    task automatic go(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rst_assert();
        rst = 1'b0;
        e_lvl = '0; e_press = '0; e_rel = '0; e_rpt = '0;
        for (int c = 0; c < N; c++) held[c] = 1'b0;
    endtask

    task automatic rst_release();
        rst  = 1'b1;
        base = t + 1;
        for (int c = 0; c < N; c++) last_tog[c] = t;
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            last_tog[c] = 0;
            ref_r[c] = 0;
            held[c] = 1'b0;
        end
        go(3);
        rst_release();
        go(5);
        // clean press and release, no repeat
        btn_in[0] = 1'b1; go(20);
        btn_in[0] = 1'b0; go(15);
        // short glitch, then alternating bounce
        btn_in[0] = 1'b1; go(3);
        btn_in[0] = 1'b0; go(10);
        for (int i = 0; i < 20; i++) begin
            btn_in[0] = ~btn_in[0];
            go(2);
        end
        btn_in[0] = 1'b0; go(10);
        // auto-repeat, release mid-stream
        repeat_en[0] = 1'b1;
        btn_in[0] = 1'b1; go(23);
        btn_in[0] = 1'b0; go(15);
        // repeat disable mid-hold
        btn_in[0] = 1'b1; go(17);
        repeat_en[0] = 1'b0; go(13);
        repeat_en[0] = 1'b1; go(15);
        btn_in[0] = 1'b0; go(10);
        repeat_en[0] = 1'b0;
        // two independent channels
        btn_in[0] = 1'b1; go(2);
        btn_in[1] = 1'b1; go(15);
        btn_in = '0; go(12);
        // async reset mid-hold
        repeat_en[0] = 1'b1;
        btn_in[0] = 1'b1; go(12);
        #2;
        rst_assert();
        #1;
        check_all();
        go(3);
        rst_release();
        go(15);
        btn_in[0] = 1'b0; go(12);
        // random phase
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) btn_in[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 24) == 0) repeat_en[$urandom_range(0, N - 1)] ^= 1'b1;
            if (rst && $urandom_range(0, 299) == 0) rst_assert();
            else if (!rst && $urandom_range(0, 2) == 0) rst_release();
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
